// File: rtl/reg_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_cmd_ctrl_if
//  Description : Bundle between the UART-facing command controller and its
//                environment (UART receiver/transmitter and register file).
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  Rd_VLD;
    logic                  TX_BUSY;
    logic [ADDR_WIDTH-1:0] Address;
    logic                  WrEn;
    logic                  RdEn;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  CMD_ERR;

    // Controller side
    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, Rd_VLD, TX_BUSY,
        output Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    // Environment side (UART + register file)
    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, Rd_VLD, TX_BUSY,
        input  Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface
`default_nettype wire

// File: rtl/reg_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_cmd_ctrl
//  Description : Byte-oriented command decoder. Write frame: WR_CMD, addr,
//                data -> WrEn. Read frame: RD_CMD, addr -> RdEn, wait for
//                Rd_VLD (with timeout), forward RdData to the UART TX.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    RD_TIMEOUT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    reg_cmd_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_EXEC = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_EXEC = 3'd5,
        S_RD_WAIT = 3'd6,
        S_TX_SEND = 3'd7
    } state_t;

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    // CMD_ERR is registered, so the timeout decision is taken one RD_WAIT
    // cycle early; the strobe then appears exactly RD_TIMEOUT cycles after
    // the RdEn cycle, and Rd_VLD is accepted in the RD_TIMEOUT-1 cycles
    // in between.
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(RD_TIMEOUT - 2);

    state_t                r_state;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic                  r_tx_vld;
    logic                  r_cmd_err;

    // Address byte is legal only if every bit above the address field is 0
    logic w_addr_hi_bad;
    assign w_addr_hi_bad = (bus.RX_P_DATA >> ADDR_WIDTH) != '0;

    // Frame sequencer: state, latched data and single-cycle strobes
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_rd_cnt  <= '0;
            r_address <= '0;
            r_wr_data <= '0;
            r_tx_data <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            // strobes default low so each one lasts a single cycle
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.RX_D_VLD) begin
                        if (bus.RX_P_DATA == WR_CMD) begin
                            r_state <= S_WR_ADDR;
                        end else if (bus.RX_P_DATA == RD_CMD) begin
                            r_state <= S_RD_ADDR;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end

                S_WR_ADDR, S_RD_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        if (w_addr_hi_bad) begin
                            r_cmd_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                            if (r_state == S_WR_ADDR) begin
                                r_state <= S_WR_DATA;
                            end else begin
                                // RdEn raised here so it is high throughout RD_EXEC
                                r_rd_en <= 1'b1;
                                r_state <= S_RD_EXEC;
                            end
                        end
                    end
                end

                S_WR_DATA: begin
                    if (bus.RX_D_VLD) begin
                        r_wr_data <= bus.RX_P_DATA;
                        r_wr_en   <= 1'b1;
                        r_state   <= S_WR_EXEC;
                    end
                end

                S_WR_EXEC: begin
                    r_cmd_err <= bus.RX_D_VLD;
                    r_state   <= S_IDLE;
                end

                S_RD_EXEC: begin
                    r_cmd_err <= bus.RX_D_VLD;
                    r_rd_cnt  <= '0;
                    r_state   <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    r_cmd_err <= bus.RX_D_VLD;
                    if (bus.Rd_VLD) begin
                        r_tx_data <= bus.RdData;
                        r_state   <= S_TX_SEND;
                    end else if (r_rd_cnt == c_TO_LAST) begin
                        r_cmd_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end

                S_TX_SEND: begin
                    r_cmd_err <= bus.RX_D_VLD;
                    if (!bus.TX_BUSY) begin
                        r_tx_vld <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Address   = r_address;
    assign bus.WrData    = r_wr_data;
    assign bus.TX_P_DATA = r_tx_data;
    assign bus.WrEn      = r_wr_en;
    assign bus.RdEn      = r_rd_en;
    assign bus.TX_D_VLD  = r_tx_vld;
    assign bus.CMD_ERR   = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_cmd_ctrl
//  Description : Self-checking bench for reg_cmd_ctrl. Directed frames plus
//                randomized write/read/error frames, checked against a
//                register-array model of the frame protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_cmd_ctrl;

    localparam int          DW  = 8;
    localparam int          AW  = 4;
    localparam int          TO  = 4;
    localparam logic [7:0]  WRC = 8'hAA;
    localparam logic [7:0]  RDC = 8'hBB;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    reg_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_cmd_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WR_CMD(WRC), .RD_CMD(RDC), .RD_TIMEOUT(TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Expected register contents, from the frames the bench intended to write
    logic [7:0] model_rf [16];
    // Register file as the environment sees it, written only by DUT WrEn
    logic [7:0] env_rf   [16];

    int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0, n_both = 0;

    // register file written by the DUT, cleared together with the system
    always @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) env_rf[i] <= 8'h00;
        end else if (bus.WrEn) begin
            env_rf[bus.Address] <= bus.WrData;
        end
    end

    // strobe counters sampled mid-cycle
    always @(negedge CLK) begin
        if (bus.WrEn)             n_wr++;
        if (bus.RdEn)             n_rd++;
        if (bus.TX_D_VLD)         n_tx++;
        if (bus.CMD_ERR)          n_err++;
        if (bus.WrEn && bus.RdEn) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model_rf[i] = 8'h00;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wren"},  32'(bus.WrEn),     32'd0);
        chk({tag, "_rden"},  32'(bus.RdEn),     32'd0);
        chk({tag, "_txvld"}, 32'(bus.TX_D_VLD), 32'd0);
        chk({tag, "_err"},   32'(bus.CMD_ERR),  32'd0);
    endtask

    // Full write frame; optional junk byte lands in the WrEn cycle
    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input bit junk);
        int w0;
        w0 = n_wr;
        send(WRC);
        send({4'h0, a});
        send(d);
        chk("wr_en",   32'(bus.WrEn),    32'd1);
        chk("wr_addr", 32'(bus.Address), 32'(a));
        chk("wr_data", 32'(bus.WrData),  32'(d));
        chk("wr_rden", 32'(bus.RdEn),    32'd0);
        model_rf[a] = d;
        if (junk) begin
            bus.RX_P_DATA = 8'($urandom);
            bus.RX_D_VLD  = 1'b1;
        end
        tick();
        bus.RX_D_VLD = 1'b0;
        chk("wr_en_off",   32'(bus.WrEn),    32'd0);
        chk("wr_junk_err", 32'(bus.CMD_ERR), 32'(junk));
        chk("wr_once",     32'(n_wr - w0),   32'd1);
    endtask

    // Full read frame: Rd_VLD `lat` cycles after RdEn, TX_BUSY for `busy` cycles
    task automatic do_read(input logic [3:0] a, input int lat, input int busy, input bit junk);
        int r0, t0;
        r0 = n_rd;
        t0 = n_tx;
        send(RDC);
        send({4'h0, a});
        chk("rd_en",   32'(bus.RdEn),    32'd1);
        chk("rd_addr", 32'(bus.Address), 32'(a));
        chk("rd_wren", 32'(bus.WrEn),    32'd0);
        bus.TX_BUSY = (busy > 0);
        for (int k = 1; k <= lat; k++) begin
            tick();
            bus.RX_D_VLD = 1'b0;
            if (k >= 2) chk("rd_wait_err", 32'(bus.CMD_ERR), 32'(junk && k == 2));
            chk("rd_wait_tx", 32'(bus.TX_D_VLD), 32'd0);
            if (junk && k == 1 && lat >= 2) begin
                bus.RX_P_DATA = 8'($urandom);
                bus.RX_D_VLD  = 1'b1;
            end
            if (k == lat) begin
                bus.Rd_VLD = 1'b1;
                bus.RdData = env_rf[a];
            end
        end
        tick();
        bus.Rd_VLD = 1'b0;
        bus.RdData = 8'($urandom);
        chk("rd_latched", 32'(bus.TX_P_DATA), 32'(model_rf[a]));
        for (int i = 0; i < busy; i++) begin
            chk("rd_busy_tx", 32'(bus.TX_D_VLD), 32'd0);
            tick();
        end
        bus.TX_BUSY = 1'b0;
        chk("rd_pre_tx", 32'(bus.TX_D_VLD), 32'd0);
        tick();
        chk("rd_tx_vld",  32'(bus.TX_D_VLD),  32'd1);
        chk("rd_tx_data", 32'(bus.TX_P_DATA), 32'(model_rf[a]));
        tick();
        chk("rd_tx_off",  32'(bus.TX_D_VLD), 32'd0);
        chk("rd_rd_once", 32'(n_rd - r0),    32'd1);
        chk("rd_tx_once", 32'(n_tx - t0),    32'd1);
    endtask

    // Read frame whose register file never answers
    task automatic do_timeout(input logic [3:0] a);
        int e0, t0;
        e0 = n_err;
        t0 = n_tx;
        send(RDC);
        send({4'h0, a});
        chk("to_rden", 32'(bus.RdEn), 32'd1);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("to_early_err", 32'(bus.CMD_ERR), 32'd0);
        end
        tick();
        chk("to_err", 32'(bus.CMD_ERR), 32'd1);
        // late answer arrives after the frame was abandoned
        bus.Rd_VLD = 1'b1;
        bus.RdData = 8'($urandom);
        tick();
        bus.Rd_VLD = 1'b0;
        chk("to_err_off", 32'(bus.CMD_ERR), 32'd0);
        tick();
        tick();
        chk("to_no_tx",   32'(n_tx - t0),  32'd0);
        chk("to_err_one", 32'(n_err - e0), 32'd1);
    endtask

    task automatic do_bad_cmd(input logic [7:0] b);
        send(b);
        chk("badcmd_err",  32'(bus.CMD_ERR), 32'd1);
        chk("badcmd_wren", 32'(bus.WrEn),    32'd0);
        tick();
        chk("badcmd_off",  32'(bus.CMD_ERR), 32'd0);
    endtask

    task automatic do_bad_addr(input bit is_wr, input logic [7:0] b);
        int w0, r0;
        w0 = n_wr;
        r0 = n_rd;
        send(is_wr ? WRC : RDC);
        send(b);
        chk("badaddr_err", 32'(bus.CMD_ERR), 32'd1);
        tick();
        tick();
        chk_idle_outputs("badaddr_after");
        chk("badaddr_nowr", 32'(n_wr - w0), 32'd0);
        chk("badaddr_nord", 32'(n_rd - r0), 32'd0);
    endtask

    initial begin
        int op, lat, busy;
        logic [7:0] b;
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD  = 1'b0;
        bus.RdData    = '0;
        bus.Rd_VLD    = 1'b0;
        bus.TX_BUSY   = 1'b0;
        clear_model();

        // reset state
        RST = 1'b0;
        tick();
        tick();
        chk_idle_outputs("rst");
        chk("rst_addr",  32'(bus.Address),   32'd0);
        chk("rst_wdata", 32'(bus.WrData),    32'd0);
        chk("rst_txd",   32'(bus.TX_P_DATA), 32'd0);
        RST = 1'b1;
        tick();

        // write AA 03 5C
        do_write(4'h3, 8'h5C, 1'b0);
        chk("rf3_holds", 32'(env_rf[3]), 32'h5C);
        // read of reg2 = 1D with no stall
        do_write(4'h2, 8'h1D, 1'b0);
        do_read(4'h2, 1, 0, 1'b0);
        // read of reg3 = 08 held off by 10 busy cycles
        do_write(4'h3, 8'h08, 1'b0);
        do_read(4'h3, 2, 10, 1'b0);
        // bad command and bad address
        do_bad_cmd(8'h3C);
        do_bad_addr(1'b1, 8'h13);
        do_write(4'h6, 8'hE1, 1'b0);
        // timeout
        do_timeout(4'h1);
        do_read(4'h6, TO - 1, 0, 1'b0);
        // bytes arriving mid-execution are dropped
        do_write(4'h9, 8'h42, 1'b1);
        do_read(4'h9, 3, 1, 1'b1);

        // reset mid-frame
        begin
            int w0;
            w0 = n_wr;
            send(WRC);
            send(8'h05);
            RST = 1'b0;
            tick();
            RST = 1'b1;
            clear_model();
            chk("midrst_addr", 32'(bus.Address), 32'd0);
            send(8'h77);
            chk("midrst_err",  32'(bus.CMD_ERR), 32'd1);
            chk("midrst_wren", 32'(bus.WrEn),    32'd0);
            tick();
            tick();
            chk("midrst_nowr", 32'(n_wr - w0),   32'd0);
        end

        // randomized frames
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1: do_write(4'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
                2, 3: begin
                    lat  = $urandom_range(1, TO - 1);
                    busy = $urandom_range(0, 3);
                    do_read(4'($urandom), lat, busy, (lat >= 2) && ($urandom_range(0, 2) == 0));
                end
                4: begin
                    b = 8'($urandom);
                    if (b == WRC || b == RDC) b = 8'h00;
                    do_bad_cmd(b);
                end
                5: do_bad_addr($urandom_range(0, 1) == 1,
                               {4'($urandom_range(1, 15)), 4'($urandom)});
                default: do_timeout(4'($urandom));
            endcase
        end

        // final register sweep through the read path
        for (int i = 0; i < 16; i++) do_read(4'(i), 1, 0, 1'b0);

        chk("never_wr_and_rd", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of received bytes, write data, read data and transmit data.
REQ-002 Parameter ADDR_WIDTH, default 4: width of the register address.
REQ-003 Parameter WR_CMD, default 8'hAA: command byte that opens a write frame.
REQ-004 Parameter RD_CMD, default 8'hBB: command byte that opens a read frame.
REQ-005 Parameter RD_TIMEOUT, default 4: maximum cycles to wait for Rd_VLD after RdEn.
REQ-006 Reset polarity and clocking are fixed: one clock; reset is synchronous and active-low.
REQ-007 CLK  in  1  single clock; all state updates on its rising edge.
REQ-008 RST  in  1  synchronous active-low reset.
REQ-009 RX_P_DATA  in  DATA_WIDTH  received byte from the UART receiver.
REQ-010 RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid in that cycle.
REQ-011 RdData  in  DATA_WIDTH  read data returned by the register file.
REQ-012 Rd_VLD  in  1  RdData is valid in that cycle.
REQ-013 TX_BUSY  in  1  UART transmitter is busy and cannot accept a byte.
REQ-014 Address  out  ADDR_WIDTH  register address driven to the register file.
REQ-015 WrEn  out  1  one-cycle write strobe.
REQ-016 RdEn  out  1  one-cycle read strobe.
REQ-017 WrData  out  DATA_WIDTH  write data driven to the register file.
REQ-018 TX_P_DATA  out  DATA_WIDTH  byte offered to the UART transmitter.
REQ-019 TX_D_VLD  out  1  one-cycle strobe; TX_P_DATA is valid in that cycle.
REQ-020 CMD_ERR  out  1  one-cycle error strobe.

Function
REQ-021 The FSM SHALL have these states: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
REQ-022 IDLE, RX_D_VLD with byte == WR_CMD: go to WR_ADDR.
REQ-023 IDLE, RX_D_VLD with byte == RD_CMD: go to RD_ADDR.
REQ-024 IDLE, RX_D_VLD with any other byte: pulse CMD_ERR for one cycle and stay in IDLE.
REQ-025 WR_ADDR or RD_ADDR, RX_D_VLD: if byte[DATA_WIDTH-1:ADDR_WIDTH] != 0, pulse CMD_ERR and go to IDLE.
REQ-026 Otherwise the FSM SHALL latch byte[ADDR_WIDTH-1:0] into Address and go to WR_DATA or RD_EXEC respectively.
REQ-027 WR_DATA, RX_D_VLD: latch the byte into WrData and go to WR_EXEC.
REQ-028 WR_EXEC: WrEn=1 for exactly that one cycle, then go to IDLE.
REQ-029 Write latency: WrEn is high in the cycle after the data byte's RX_D_VLD.
REQ-030 RD_EXEC: RdEn=1 for exactly that one cycle, then go to RD_WAIT.
REQ-031 Read latency: RdEn is high in the cycle after the address byte's RX_D_VLD.
REQ-032 RD_WAIT: on Rd_VLD, latch RdData into TX_P_DATA and go to TX_SEND.
REQ-033 RD_WAIT: a cycle counter starts at 0 on entry and increments each cycle while Rd_VLD is low.
REQ-034 RD_WAIT: if the counter reaches RD_TIMEOUT without Rd_VLD, pulse CMD_ERR and go to IDLE.
REQ-035 TX_SEND: while TX_BUSY=1, hold state with TX_D_VLD=0.
REQ-036 TX_SEND: in the first cycle with TX_BUSY=0, TX_D_VLD=1 for one cycle, then go to IDLE.
REQ-037 RX_D_VLD arriving in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: drop the byte, pulse CMD_ERR, and do not change state.
REQ-038 WrEn and RdEn SHALL never be high in the same cycle.
REQ-039 WrEn and RdEn SHALL each be high for exactly one cycle per accepted frame.
REQ-040 Address, WrData and TX_P_DATA SHALL hold their last latched values until relatched.
REQ-041 Rd_VLD received outside RD_WAIT SHALL be ignored.
REQ-042 A write frame completes in 4 cycles minimum.
REQ-043 A read frame completes in at least 5 cycles plus the register file latency plus TX_BUSY stall cycles.

Reset
REQ-044 RST=0 at a rising CLK edge: FSM goes to IDLE and the timeout counter clears.
REQ-045 RST=0 at a rising CLK edge: Address, WrData, TX_P_DATA clear to 0 and WrEn, RdEn, TX_D_VLD, CMD_ERR clear to 0.
REQ-046 Reset asserted mid-frame SHALL abort the frame with no WrEn, RdEn or TX_D_VLD pulse afterwards.
REQ-047 After RST returns high, the first accepted byte is treated as a command byte.

Verification
REQ-048 Write: bytes AA, 03, 5C -> WrEn=1 one cycle after 5C with Address=3 and WrData=5C; the register file then holds 3=5C.
REQ-049 Read: bytes BB, 02 with register file reg2=1D and TX_BUSY=0 -> RdEn pulse with Address=2, then TX_D_VLD pulse with TX_P_DATA=1D.
REQ-050 Busy: read of reg3=08 with TX_BUSY=1 for 10 cycles -> TX_D_VLD stays 0 for those cycles and pulses once with 08 on the first TX_BUSY=0 cycle.
REQ-051 Errors: byte 3C in IDLE -> CMD_ERR pulse, stay IDLE; bytes AA, 13 -> CMD_ERR pulse, IDLE, no WrEn.
REQ-052 Timeout: bytes BB, 01 with Rd_VLD held 0 -> CMD_ERR pulse RD_TIMEOUT cycles after RdEn, no TX_D_VLD.
REQ-053 Reset mid-frame: AA, 05, then RST=0 for one cycle, then 77 -> no WrEn; 77 -> CMD_ERR pulse.
